// File: rtl/image_loader.sv
// Frame buffer for a 64x64 RGB888 image fed as a byte-serial R,G,B stream.
// Holds one complete frame for a downstream processor until it releases it.
module image_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_sof,
  output logic        s_ready,
  input  logic [5:0]  row,
  input  logic [5:0]  col,
  output logic [23:0] in_pix,
  output logic        frame_ready,
  input  logic        frame_release,
  output logic [12:0] pix_cnt,
  output logic        sof_err
);

  typedef enum logic {LOAD, FULL} state_t;

  state_t      state, state_nxt;
  logic [23:0] mem [0:4095];
  logic [1:0]  byte_cnt;
  logic [15:0] asm_rg;
  logic        accept;
  logic        wr_en;
  logic        last_pix;

  assign accept   = s_valid & s_ready;
  assign wr_en    = accept & ~s_sof & (byte_cnt == 2'd2);
  assign last_pix = wr_en & (pix_cnt == 13'd4095);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (last_pix) state_nxt = FULL;
      FULL:    if (frame_release) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // s_ready is gated by rst so no byte is offered while reset is held
  always_comb begin
    s_ready     = 1'b0;
    frame_ready = 1'b0;
    case (state)
      LOAD:    s_ready = ~rst;
      FULL:    frame_ready = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= 2'd0;
      pix_cnt  <= 13'd0;
      sof_err  <= 1'b0;
    end else if (state == FULL) begin
      if (frame_release) begin
        byte_cnt <= 2'd0;
        pix_cnt  <= 13'd0;
      end
    end else if (accept) begin
      if (s_sof) begin
        if (byte_cnt != 2'd0 || pix_cnt != 13'd0) sof_err <= 1'b1;
        byte_cnt <= 2'd1;
        pix_cnt  <= 13'd0;
      end else if (byte_cnt == 2'd2) begin
        byte_cnt <= 2'd0;
        pix_cnt  <= pix_cnt + 13'd1;
      end else begin
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

  // Pixel storage and R/G assembly carry no reset; memory survives rst
  always_ff @(posedge clk) begin
    if (accept && (s_sof || byte_cnt == 2'd0)) asm_rg[15:8] <= s_data;
    if (accept && !s_sof && byte_cnt == 2'd1)  asm_rg[7:0]  <= s_data;
    if (wr_en) mem[pix_cnt[11:0]] <= {asm_rg, s_data};
  end

  assign in_pix = mem[{row, col}];

endmodule

// File: tb/tb_image_loader.sv
// Bench for image_loader: byte-stream frames against a byte-count reference
// model, a table of known pixels, and hand sequences for release/sof/reset.
module tb_image_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = 8'd0;
  logic        s_valid = 1'b0;
  logic        s_sof = 1'b0;
  logic        s_ready;
  logic [5:0]  row = 6'd0;
  logic [5:0]  col = 6'd0;
  logic [23:0] in_pix;
  logic        frame_ready;
  logic        frame_release = 1'b0;
  logic [12:0] pix_cnt;
  logic        sof_err;

  image_loader dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof),
    .s_ready(s_ready), .row(row), .col(col), .in_pix(in_pix),
    .frame_ready(frame_ready), .frame_release(frame_release),
    .pix_cnt(pix_cnt), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  r;
    logic [5:0]  c;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[5];

  int checks = 0;
  int errors = 0;

  // Reference model: bytes accepted in the current frame and the image they build
  logic [23:0] ref_mem [4096];
  int          nb = 0;
  bit          m_err = 1'b0;
  logic [7:0]  mr, mg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_status(input string name);
    logic [31:0] exp;
    exp = {16'd0, m_err, (nb == 12288), (nb != 12288), 13'(nb / 3)};
    chk(name, {16'd0, sof_err, frame_ready, s_ready, pix_cnt}, exp);
  endtask

  task automatic model_accept(input logic [7:0] d, input logic sof);
    if (sof) begin
      if (nb != 0) m_err = 1'b1;
      nb = 0;
    end
    case (nb % 3)
      0:       mr = d;
      1:       mg = d;
      default: ref_mem[nb / 3] = {mr, mg, d};
    endcase
    nb++;
  endtask

  // Called at a negedge; returns at a negedge after the byte is taken
  task automatic send_byte(input logic [7:0] d, input logic sof, input bit gaps);
    int tries;
    if (gaps && $urandom_range(1) == 1) begin
      repeat ($urandom_range(1, 2)) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_sof   = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
      end
    end
    s_data  = d;
    s_sof   = sof;
    s_valid = 1'b1;
    tries = 0;
    while (!s_ready && tries < 20) begin
      @(posedge clk);
      @(negedge clk);
      tries++;
    end
    if (!s_ready) begin
      chk("accept_timeout", 32'(s_ready), 32'd1);
      s_valid = 1'b0;
      s_sof   = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(d, sof);
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    check_status("byte_status");
  endtask

  task automatic send_pixels(input int first, input int n, input bit rnd,
                             input bit gaps, input bit sof0);
    for (int k = first; k < first + n; k++) begin
      logic [23:0] px;
      logic [7:0]  kb;
      kb = k[7:0];
      px = rnd ? 24'($urandom) : {kb, 8'hA5, ~kb};
      send_byte(px[23:16], sof0 && (k == first), gaps);
      send_byte(px[15:8], 1'b0, gaps);
      send_byte(px[7:0], 1'b0, gaps);
    end
  endtask

  task automatic rd_chk(input string name, input logic [5:0] r, input logic [5:0] c,
                        input logic [23:0] exp);
    row = r;
    col = c;
    #1;
    chk(name, 32'(in_pix), 32'(exp));
    @(negedge clk);
  endtask

  task automatic mem_sweep(input string name);
    int bad;
    bad = 0;
    for (int a = 0; a < 4096; a++) begin
      row = 6'(a / 64);
      col = 6'(a % 64);
      #1;
      if (in_pix !== ref_mem[a]) bad++;
    end
    chk(name, 32'(bad), 32'd0);
    @(negedge clk);
  endtask

  task automatic release_frame();
    frame_release = 1'b1;
    @(posedge clk);
    if (nb == 12288) nb = 0;
    @(negedge clk);
    frame_release = 1'b0;
  endtask

  initial begin
    vecs[0] = '{r: 6'd0,  c: 6'd0,  exp: 24'h00A5FF};
    vecs[1] = '{r: 6'd1,  c: 6'd2,  exp: 24'h42A5BD};
    vecs[2] = '{r: 6'd2,  c: 6'd0,  exp: 24'h80A57F};
    vecs[3] = '{r: 6'd10, c: 6'd5,  exp: 24'h85A57A};
    vecs[4] = '{r: 6'd63, c: 6'd63, exp: 24'hFFA500};

    repeat (3) @(negedge clk);
    chk("reset_status", {16'd0, sof_err, frame_ready, s_ready, pix_cnt}, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(s_ready), 32'd1);
    @(negedge clk);

    // Frame 1: continuous stream, no sof
    send_pixels(0, 4096, 1'b0, 1'b0, 1'b0);
    chk("frame1_ready", 32'(frame_ready), 32'd1);
    chk("frame1_pixcnt", 32'(pix_cnt), 32'd4096);
    for (int i = 0; i < 5; i++) rd_chk("table_f1", vecs[i].r, vecs[i].c, vecs[i].exp);
    mem_sweep("sweep_f1");

    // Bytes and sof offered while FULL must be ignored
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_sof   = 1'b1;
      s_data  = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      check_status("full_hold");
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    rd_chk("full_keep_1_2", 6'd1, 6'd2, 24'h42A5BD);

    release_frame();
    check_status("release_status");
    chk("release_ready", 32'({frame_ready, s_ready}), 32'b01);
    rd_chk("release_keep_1_2", 6'd1, 6'd2, 24'h42A5BD);

    // Frame 2: same pattern with random gaps and sof, release held early on
    frame_release = 1'b1;
    send_pixels(0, 1000, 1'b0, 1'b1, 1'b1);
    frame_release = 1'b0;
    send_pixels(1000, 3096, 1'b0, 1'b1, 1'b0);
    chk("frame2_sof_err", 32'(sof_err), 32'd0);
    for (int i = 0; i < 5; i++) rd_chk("table_f2", vecs[i].r, vecs[i].c, vecs[i].exp);
    mem_sweep("sweep_f2");

    // Frame 3: sof arrives mid-frame, then a full random frame follows
    release_frame();
    send_pixels(0, 100, 1'b0, 1'b0, 1'b0);
    send_byte(8'h64, 1'b0, 1'b0);
    send_byte(8'h11, 1'b1, 1'b0);
    chk("sof_err_set", 32'(sof_err), 32'd1);
    chk("sof_pixcnt_zero", 32'(pix_cnt), 32'd0);
    send_byte(8'($urandom), 1'b0, 1'b0);
    send_byte(8'($urandom), 1'b0, 1'b0);
    send_pixels(1, 4095, 1'b1, 1'b0, 1'b0);
    chk("frame3_ready", 32'(frame_ready), 32'd1);
    row = 6'd0;
    col = 6'd0;
    #1;
    chk("frame3_pix0_r", 32'(in_pix[23:16]), 32'h11);
    @(negedge clk);
    mem_sweep("sweep_f3");

    // Frame 4: reset after 2000 random pixels
    release_frame();
    send_pixels(0, 2000, 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_reset_status", {16'd0, sof_err, frame_ready, s_ready, pix_cnt}, 32'd0);
    rd_chk("reset_keep_pix5", 6'd0, 6'd5, ref_mem[5]);
    nb = 0;
    m_err = 1'b0;
    @(negedge clk);
    chk("held_reset_ready", 32'(s_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_mid_reset", 32'(s_ready), 32'd1);
    @(negedge clk);
    send_pixels(0, 10, 1'b1, 1'b1, 1'b0);
    rd_chk("post_reset_pix9", 6'd0, 6'd9, ref_mem[9]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 The block SHALL have no parameters; image size is fixed at 64x64 pixels of 24 bits (R 23:16, G 15:8, B 7:0).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 s_data  input  8  byte-serial pixel stream, byte order per pixel R, G, B.
REQ-005 s_valid  input  1  s_data/s_sof valid this cycle.
REQ-006 s_sof  input  1  start of frame; marks the current byte as R of pixel (0,0).
REQ-007 s_ready  output  1  block accepts a byte this cycle.
REQ-008 row  input  6  read row selected by the downstream image processor.
REQ-009 col  input  6  read column selected by the downstream image processor.
REQ-010 in_pix  output  24  stored pixel at [row, col].
REQ-011 frame_ready  output  1  a complete 4096-pixel frame is stored and stable.
REQ-012 frame_release  input  1  consumer has finished with the frame (driven from the processor's final done strobe).
REQ-013 pix_cnt  output  13  pixels written in the current frame, 0..4096.
REQ-014 sof_err  output  1  sticky flag: s_sof was received mid-frame.

Function
REQ-015 Storage SHALL be a 4096x24 array addressed {row,col} for reads and by raster index (row-major, top-down, left-right) for writes.
REQ-016 in_pix SHALL be a combinational read of mem[{row,col}], valid in the same cycle row/col change.
REQ-017 A simultaneous write and read of one address SHALL return the old value until the following cycle.
REQ-018 A byte SHALL be accepted on a rising edge where s_valid and s_ready are both 1; no other byte is consumed.
REQ-019 A 2-bit byte counter SHALL step 0 (R) -> 1 (G) -> 2 (B) -> 0; R and G bytes SHALL be held in a 16-bit assembly register.
REQ-020 On acceptance of a B byte, the assembled pixel SHALL be written at raster index pix_cnt on that edge, and pix_cnt SHALL increment on the same edge.
REQ-021 The FSM SHALL have states LOAD (s_ready=1, frame_ready=0) and FULL (s_ready=0, frame_ready=1).
REQ-022 LOAD -> FULL SHALL occur on the edge that writes pixel 4095; frame_ready SHALL be 1 and s_ready 0 from the next cycle, with pix_cnt = 4096.
REQ-023 FULL -> LOAD SHALL occur on the edge where frame_release=1; pix_cnt and byte counter SHALL clear to 0 and memory contents SHALL be retained until overwritten.
REQ-024 frame_release in LOAD SHALL be ignored.
REQ-025 An accepted byte with s_sof=1 SHALL be taken as R of pixel 0: byte counter -> 1, pix_cnt -> 0, R stored.
REQ-026 If s_sof is accepted while byte counter or pix_cnt is non-zero, sof_err SHALL be set to 1 and remain 1 until reset; the partial frame is abandoned and written pixels are overwritten by the new frame.
REQ-027 s_sof is not required; a frame starting from counters at zero without s_sof SHALL load normally.
REQ-028 s_sof or s_data presented while in FULL SHALL not be consumed and SHALL not affect any state.

Reset
REQ-029 While rst=1: state LOAD, s_ready=0, frame_ready=0, pix_cnt=0, byte counter 0, sof_err=0; memory SHALL not be cleared.
REQ-030 s_ready SHALL become 1 in the first cycle after rst deasserts.
REQ-031 Reset asserted mid-frame or in FULL SHALL abandon the frame immediately; in_pix SHALL still reflect existing memory contents.

Verification
REQ-032 Stream 12288 bytes, pixel k = {k[7:0], 8'hA5, ~k[7:0]}, s_valid always 1 -> frame_ready=1 one cycle after byte 12288, pix_cnt=4096, in_pix at row 1 col 2 = 24'h42A5BD.
REQ-033 Random s_valid gaps (about 50%) during the same stream -> identical memory contents; s_ready=0 and no byte consumed while frame_ready=1.
REQ-034 In FULL, pulse frame_release for one cycle -> frame_ready=0 and s_ready=1 the next cycle, pix_cnt=0, in_pix at (1,2) still 24'h42A5BD until overwritten.
REQ-035 After 100 pixels plus 1 byte, send s_sof with R=8'h11 -> sof_err=1, pix_cnt=0; a full frame then completes with pixel 0 R=8'h11.
REQ-036 Assert rst after 2000 pixels -> pix_cnt=0, frame_ready=0, s_ready=0 during reset and 1 after; previously written pixel 5 readable unchanged.
REQ-037 frame_release held during LOAD -> no state change; frame completes normally.
